// File: rtl/mem_resp.sv
// mem_resp: fixed-latency word-memory responder with Stall/Done handshake.
// Define MEM_RESP_HIT_EN to add a single-entry read hit buffer (CacheHit fast path).
module mem_resp #(
    parameter int DEPTH_LOG2 = 8,
    parameter int LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Rd,
    input  logic        Wr,
    input  logic [15:0] Addr,
    input  logic [15:0] DataIn,
    output logic [15:0] DataOut,
    output logic        Done,
    output logic        Stall,
    output logic        CacheHit,
    output logic        err
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state, state_nx;
    logic [3:0] cnt;
    logic l_rd, l_wr, l_err, l_hit;
    logic [DEPTH_LOG2-1:0] l_idx;
    logic [15:0] l_din, rd_data;
    logic [15:0] mem [0:2**DEPTH_LOG2-1];
    logic req, in_err, hit_now, done;
    assign req = Rd | Wr;
    assign done = state == DONE;
    assign in_err = Addr[0] | (|(Addr >> (DEPTH_LOG2 + 1))) | (Rd & Wr);
    always_comb begin
        state_nx = state == DONE ? IDLE :
                   state == BUSY ? (cnt == 4'd1 ? DONE : BUSY) :
                   req ? ((LATENCY == 1 || hit_now) ? DONE : BUSY) : IDLE;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            l_rd  <= 1'b0;
            l_wr  <= 1'b0;
            l_err <= 1'b0;
            l_hit <= 1'b0;
            l_idx <= '0;
            l_din <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && req) begin
                cnt   <= 4'(LATENCY - 1);
                l_rd  <= Rd;
                l_wr  <= Wr;
                l_err <= in_err;
                l_hit <= hit_now;
                l_idx <= Addr[DEPTH_LOG2:1];
                l_din <= DataIn;
            end else if (state == BUSY) begin
                cnt <= cnt - 4'd1;
            end
        end
    end
    // array has no reset; contents persist across rst
    always_ff @(posedge clk) begin
        if (done && l_wr && !l_err)
            mem[l_idx] <= l_din;
    end
`ifdef MEM_RESP_HIT_EN
    logic hv;
    logic [DEPTH_LOG2-1:0] h_idx;
    logic [15:0] h_data;
    assign hit_now = hv && h_idx == Addr[DEPTH_LOG2:1] && Rd && !in_err;
    assign rd_data = l_hit ? h_data : mem[l_idx];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hv     <= 1'b0;
            h_idx  <= '0;
            h_data <= '0;
        end else if (done && !l_err) begin
            hv     <= 1'b1;
            h_idx  <= l_idx;
            h_data <= l_wr ? l_din : rd_data;
        end
    end
`else
    assign hit_now = 1'b0;
    assign rd_data = mem[l_idx];
`endif
    assign Done = done;
    assign err = done & l_err;
    assign CacheHit = done & l_hit;
    assign DataOut = (done && l_rd && !l_err) ? rd_data : 16'h0000;
    assign Stall = ~rst & ((state == BUSY) | ((state == IDLE) & req));
endmodule

// File: tb/tb_mem_resp.sv
// tb_mem_resp: randomized self-checking bench for mem_resp against a word-array reference model.
module tb_mem_resp;
    logic clk = 0, rst = 0, Rd = 0, Wr = 0;
    logic [15:0] Addr = 0, DataIn = 0, DataOut;
    logic Done, Stall, CacheHit, err;
    int checks = 0, failures = 0;
    logic [15:0] ref_mem [256];
    bit hv = 0;
    int h_idx = 0;

    mem_resp dut (
        .clk(clk), .rst(rst), .Rd(Rd), .Wr(Wr), .Addr(Addr), .DataIn(DataIn),
        .DataOut(DataOut), .Done(Done), .Stall(Stall), .CacheHit(CacheHit), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic outputs_zero(input string tag);
        check(tag, {DataOut, Done, Stall, CacheHit, err}, 0);
    endtask

    // call at posedge+1 with the responder idle
    task automatic xact(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] d, input bit scramble);
        bit e, hit;
        int idx, lat, c;
        logic [15:0] exp_d;
        e = a[0] || (a[15:9] != 0) || (rd && wr);
        idx = int'(a[8:1]);
        hit = 0;
`ifdef MEM_RESP_HIT_EN
        hit = hv && h_idx == idx && rd && !wr && !e;
`endif
        lat = hit ? 1 : 4;
        exp_d = (rd && !e) ? ref_mem[idx] : 16'h0000;
        Rd = rd; Wr = wr; Addr = a; DataIn = d;
        for (c = 0; c < 20; c++) begin
            @(negedge clk);
            if (Done) break;
            check("stall_busy", Stall, 1);
            check("flags_busy", {err, CacheHit, DataOut}, 0);
            @(posedge clk); #1;
            if (scramble) begin
                Addr = 16'($urandom); DataIn = 16'($urandom);
                Rd = 1'($urandom); Wr = 1'($urandom);
            end
        end
        check("latency", c, lat);
        check("done", Done, 1);
        check("stall_done", Stall, 0);
        check("err", err, e);
        check("hit", CacheHit, hit);
        check("data", DataOut, exp_d);
        if (!e) begin
            if (wr) ref_mem[idx] = d;
            hv = 1;
            h_idx = idx;
        end
        @(posedge clk); #1;
        Rd = 0; Wr = 0;
    endtask

    initial begin
        #2 rst = 1;
        #1 outputs_zero("reset_async");
        @(posedge clk); @(posedge clk); #1 rst = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("idle_after_reset", {Stall, Done}, 0);
        end
        @(posedge clk); #1;
        for (int i = 0; i < 256; i++) xact(0, 1, 16'(i * 2), 16'($urandom), 0);
        xact(0, 1, 16'h0010, 16'hBEEF, 0);
        xact(1, 0, 16'h0010, 16'h0000, 0);
        xact(1, 0, 16'h0011, 16'h0000, 0);
        xact(1, 1, 16'h0020, 16'h5555, 0);
        xact(1, 0, 16'h0020, 16'h0000, 0);
        xact(1, 0, 16'h8000, 16'h0000, 0);
        xact(0, 1, 16'h8000, 16'h7777, 0);
        xact(0, 1, 16'h0050, 16'hA5A5, 1);
        xact(1, 0, 16'h0052, 16'h0000, 1);
        xact(1, 0, 16'h0050, 16'h0000, 1);
        xact(0, 1, 16'h0030, 16'h1234, 0);
        Wr = 1; Addr = 16'h0030; DataIn = 16'hFFFF;
        @(posedge clk); @(posedge clk); #2 rst = 1;
        #1 outputs_zero("reset_mid_busy");
        Wr = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("no_done_in_reset", Done, 0);
        end
        @(posedge clk); #1 rst = 0;
        hv = 0;
        @(negedge clk);
        check("no_done_after_reset", {Done, Stall}, 0);
        @(posedge clk); #1;
        xact(1, 0, 16'h0030, 16'h0000, 0);
        xact(0, 1, 16'h0040, 16'hCAFE, 0);
        xact(1, 0, 16'h0040, 16'h0000, 0);
        xact(1, 0, 16'h0042, 16'h0000, 0);
        xact(1, 0, 16'h0042, 16'h0000, 0);
        for (int n = 0; n < 300; n++) begin
            int r;
            logic [15:0] a;
            r = $urandom_range(0, 9);
            a = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 255) * 2) : 16'($urandom_range(0, 7) * 2);
            if ($urandom_range(0, 9) == 0) a[0] = 1'b1;
            if ($urandom_range(0, 14) == 0) a[15 - $urandom_range(0, 6)] = 1'b1;
            xact(r == 0 || r > 4, r < 5, a, 16'($urandom), 1);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_resp.md
Name: mem_resp

Overview:
- Memory-side responder for the data-memory request interface driven by the pipeline's memory stage.
- Accepts single-word read/write requests (Rd, Wr, Addr, DataIn) and services them from an internal word array after a fixed latency.
- Holds the requester with Stall; completes each transaction with a one-cycle Done pulse carrying DataOut and err.
- Replaces the behavioural stall-memory model in the pipeline test environment.

Parameters:
- DEPTH_LOG2, 8, log2 of word count; array holds 2^DEPTH_LOG2 16-bit words.
- LATENCY, 4, cycles from request acceptance to Done; legal range 1..15.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- Rd  input  1  read request.
- Wr  input  1  write request.
- Addr  input  16  byte address; word index is Addr[DEPTH_LOG2:1].
- DataIn  input  16  write data.
- DataOut  output  16  read data; valid only while Done=1, otherwise 16'h0000.
- Done  output  1  one-cycle completion pulse.
- Stall  output  1  requester must hold its request and freeze.
- CacheHit  output  1  fast-path hit indicator; see Optional Feature.
- err  output  1  error flag; valid only while Done=1.

Behaviour:
- Reset (asynchronous): state=IDLE, counter=0, latched request cleared; Done=0, Stall=0, err=0, CacheHit=0, DataOut=0.
- The array is not reset; contents survive reset. Reset mid-transaction aborts it and discards a pending write.
- FSM states: IDLE, BUSY, DONE.
- req = Rd|Wr.
- IDLE, req=1:
  - Latch Rd, Wr, Addr, DataIn.
  - counter=LATENCY-1.
  - Next state is BUSY when LATENCY>1, else DONE.
- IDLE, req=0: remain in IDLE.
- BUSY: decrement counter each cycle. At counter==1 go to DONE.
- DONE, one cycle:
  - Done=1.
  - Read: DataOut=array[latched index].
  - Write: array updated on this cycle's edge; DataOut=0.
  - Next state IDLE.
- Latency: a request first seen in cycle 0 produces Done in cycle LATENCY.
- Stall is combinational: Stall = (state==BUSY) | (state==IDLE & req). Stall=0 in the Done cycle.
- Request inputs that change after acceptance are ignored; the latched copy is used.
- The requester deasserts or changes its request in the cycle after Done. A new request seen in that cycle is accepted normally, giving back-to-back transactions.
- err conditions (err=1 at Done, no array write, DataOut=0, full latency still applied):
  - Addr[0]=1 (unaligned).
  - Addr[15:DEPTH_LOG2+1]!=0 (out of range).
  - Rd&Wr both set.
- Without errors, err=0 at Done.
- Done, err and CacheHit are never high outside the Done cycle.

Optional Feature:
- Macro: MEM_RESP_HIT_EN.
- Defined:
  - Adds a single-entry buffer {valid, word index, data}, invalidated by reset.
  - Each error-free completed read or write loads the buffer with its index and data.
  - A read accepted in IDLE whose index matches a valid entry goes directly to DONE. Done occurs in cycle 1 with CacheHit=1 and DataOut=buffer data; the array is not accessed.
  - Stall=1 only in the accept cycle.
  - A write never hits; it takes full latency.
  - Error requests never hit.
- Not defined:
  - No buffer; CacheHit is tied to 0.
  - Every access takes LATENCY cycles.

Test Plan:
- Reset: assert rst mid-cycle with no clock edge -> all outputs 0 immediately. Release, hold Rd=Wr=0 for 5 cycles -> Stall=0, Done=0.
- Write/read, LATENCY=4:
  - Wr, Addr=16'h0010, DataIn=16'hBEEF at cycle 0 -> Stall=1 in cycles 0-3, Done=1/err=0 in cycle 4.
  - Then Rd Addr=16'h0010 -> DataOut=16'hBEEF with Done in cycle 4 of the read.
- Errors:
  - Rd Addr=16'h0011 -> Done after 4 cycles with err=1, DataOut=0.
  - Rd=Wr=1 Addr=16'h0020 -> err=1, and a later read of 16'h0020 returns its prior value.
  - Addr=16'h8000 with DEPTH_LOG2=8 -> err=1.
- Input changes mid-transaction: change Addr and DataIn during BUSY -> the originally latched request completes unchanged.
- Reset during BUSY of a write to 16'h0030 (previously 16'h1234) -> Done never asserts. A following read returns 16'h1234.
- MEM_RESP_HIT_EN defined:
  - Write 16'h0040=16'hCAFE, then read 16'h0040 -> Done the cycle after acceptance with CacheHit=1, DataOut=16'hCAFE.
  - Read 16'h0042 -> 4-cycle latency, CacheHit=0.
- MEM_RESP_HIT_EN undefined: same sequence -> every read takes 4 cycles, CacheHit=0.
